// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Sequential instruction fetcher with a small prefetch buffer. While the FSM
//   is in FETCH it reads one 32-bit word per cycle from a combinational
//   instruction memory. It pushes {pc, instruction} into the buffer and
//   advances the fetch pc by 4. The consumer drains the buffer head with a
//   valid/ready handshake. A redirect flushes the buffer and restarts
//   fetching at the redirect target.
//
// Parameters:
//   size_address : byte-address width of the instruction memory port
//   RESET_PC     : fetch address loaded on reset
//   FIFO_DEPTH   : prefetch buffer entries (power of two, 2..8)
//
// Ports:
//   clk             in   single clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   fetch_en        in   enables memory reads and buffer pushes
//   mem_address     out  byte address to instruction memory (= fetch pc)
//   mem_instruction in   same-cycle read data from instruction memory
//   redirect_valid  in   branch/jump redirect request
//   redirect_pc     in   redirect target byte address
//   out_valid       out  buffer head holds a valid instruction
//   out_ready       in   consumer accepts the head this cycle
//   out_instruction out  head instruction (0 while the buffer is empty)
//   out_pc          out  head instruction address (0 while the buffer is empty)
//   fetch_count     out  number of instructions accepted by the consumer
//   misalign_err    out  sticky misaligned-redirect flag
//
// Build option:
//   IFU_MISALIGN_CHECK_EN  When defined, a redirect whose target has nonzero
//                          bits [1:0] sets misalign_err. That flag is sticky
//                          until reset. The redirect still flushes the
//                          buffer, and the fetcher is parked in IDLE until
//                          reset. When undefined, bits [1:0] of the target
//                          are forced to zero and misalign_err is tied low.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          size_address = 10,
  parameter int unsigned RESET_PC     = 0,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en,
  output logic [size_address-1:0] mem_address,
  input  logic [31:0]             mem_instruction,
  input  logic                    redirect_valid,
  input  logic [size_address-1:0] redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instruction,
  output logic [size_address-1:0] out_pc,
  output logic [31:0]             fetch_count,
  output logic                    misalign_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state, state_next;

  logic [size_address-1:0] fetch_pc;
  logic [size_address-1:0] fetch_pc_next;
  logic [size_address-1:0] redirect_target;

  logic [size_address-1:0] buf_pc    [FIFO_DEPTH];
  logic [31:0]             buf_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic lock_idle;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // ---------------------------------------------------------------------------
  // Redirect target and misalignment handling
  // ---------------------------------------------------------------------------
`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_now;

  assign misalign_now    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_target = redirect_pc;

  // The error flag is sticky. Only reset can clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (misalign_now) begin
      misalign_q <= 1'b1;
    end
  end

  // Once a misaligned redirect is seen, the fetcher stays parked in IDLE.
  assign lock_idle    = misalign_q | misalign_now;
  assign misalign_err = misalign_q;
`else
  // Word alignment is forced by clearing the two low address bits.
  assign redirect_target = redirect_pc & ~size_address'(3);
  assign lock_idle       = 1'b0;
  assign misalign_err    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, plus the push/pop decisions and the next fetch pc.
  // A redirect wins over everything else: it suppresses both the push and the
  // pop, so the flushed cycle never counts as a delivered instruction.
  // A full buffer can still take a push when the head is popped in the same
  // cycle. The occupancy then stays at full and no entry is lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = IDLE;
    push          = 1'b0;
    pop           = 1'b0;
    fetch_pc_next = fetch_pc;

    if (fetch_en && !lock_idle) begin
      state_next = FETCH;
    end

    if (redirect_valid) begin
      fetch_pc_next = redirect_target;
    end else begin
      pop = !empty && out_ready;
      if ((state == FETCH) && (!full || pop)) begin
        push          = 1'b1;
        fetch_pc_next = fetch_pc + size_address'(4);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch pc register. The +4 increment wraps modulo 2^size_address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= size_address'(RESET_PC);
    end else begin
      fetch_pc <= fetch_pc_next;
    end
  end

  assign mem_address = fetch_pc;

  // ---------------------------------------------------------------------------
  // Buffer control. Pointers wrap naturally because the depth is a power of
  // two. The asynchronous reset empties the buffer immediately, which drops
  // out_valid without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage. No reset is needed here, because the output mux hides
  // every slot while the buffer is empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fetch_pc;
      buf_instr[wr_ptr] <= mem_instruction;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. The outputs are forced to zero while empty, so reset
  // and flush never expose stale entries.
  // ---------------------------------------------------------------------------
  assign out_valid       = !empty;
  assign out_pc          = empty ? '0 : buf_pc[rd_ptr];
  assign out_instruction = empty ? '0 : buf_instr[rd_ptr];

  // ---------------------------------------------------------------------------
  // Delivered-instruction counter. It wraps naturally at 2^32.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Purpose:
//   Self-checking bench for instruction_fetch_unit with default parameters
//   (10-bit addresses, RESET_PC = 0, two-entry buffer). The memory model
//   returns word index i for byte address 4*i.
//
// Each table row holds the inputs for one cycle and the outputs expected
// after the following rising edge. Asynchronous reset behaviour is exercised
// by hand-written sequences between the table segments.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [9:0]  mem_address;
  logic [31:0] mem_instruction;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [9:0]  out_pc;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int checks;
  int failures;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [9:0]  rpc;
    logic        valid;
    logic [9:0]  pc;
    logic [31:0] instr;
    logic [9:0]  mem;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  localparam int NUM_VECS = 31;
  vec_t vecs [NUM_VECS];

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_address    (mem_address),
    .mem_instruction(mem_instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .fetch_count    (fetch_count),
    .misalign_err   (misalign_err)
  );

  // Memory word at byte address 4*i holds the value i.
  assign mem_instruction = {24'd0, mem_address[9:2]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                              input logic [9:0] rpc, input logic valid,
                              input logic [9:0] pc, input logic [31:0] instr,
                              input logic [9:0] mem, input logic [31:0] cnt,
                              input logic mis);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.valid = valid; v.pc = pc; v.instr = instr; v.mem = mem;
    v.cnt = cnt; v.mis = mis;
    return v;
  endfunction

  task automatic checkVal(input string name, input int row,
                          input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, actual, expected);
    end
  endtask

  task automatic checkOutput(input int idx);
    checkVal("out_valid",       idx, 32'(out_valid),       32'(vecs[idx].valid));
    checkVal("out_pc",          idx, 32'(out_pc),          32'(vecs[idx].pc));
    checkVal("out_instruction", idx, out_instruction,      vecs[idx].instr);
    checkVal("mem_address",     idx, 32'(mem_address),     32'(vecs[idx].mem));
    checkVal("fetch_count",     idx, fetch_count,          vecs[idx].cnt);
    checkVal("misalign_err",    idx, 32'(misalign_err),    32'(vecs[idx].mis));
  endtask

  task automatic applyStimulus(input int idx);
    fetch_en       = vecs[idx].fe;
    out_ready      = vecs[idx].rdy;
    redirect_valid = vecs[idx].rv;
    redirect_pc    = vecs[idx].rpc;
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  task automatic checkResetState(input int tag);
    checkVal("rst_out_valid",   tag, 32'(out_valid),   32'd0);
    checkVal("rst_out_pc",      tag, 32'(out_pc),      32'd0);
    checkVal("rst_out_instr",   tag, out_instruction,  32'd0);
    checkVal("rst_fetch_count", tag, fetch_count,      32'd0);
    checkVal("rst_mem_address", tag, 32'(mem_address), 32'd0);
    checkVal("rst_misalign",    tag, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Segment 1: stream from reset, stall, redirects, wrap, IDLE behaviour.
    vecs[0]  = mk(1, 1, 0, 10'h000, 0, 10'h000, 32'h00, 10'h000, 0, 0);
    vecs[1]  = mk(1, 1, 0, 10'h000, 1, 10'h000, 32'h00, 10'h004, 0, 0);
    vecs[2]  = mk(1, 1, 0, 10'h000, 1, 10'h004, 32'h01, 10'h008, 1, 0);
    vecs[3]  = mk(1, 1, 0, 10'h000, 1, 10'h008, 32'h02, 10'h00C, 2, 0);
    vecs[4]  = mk(1, 0, 0, 10'h000, 1, 10'h008, 32'h02, 10'h010, 2, 0);
    vecs[5]  = mk(1, 0, 0, 10'h000, 1, 10'h008, 32'h02, 10'h010, 2, 0);
    vecs[6]  = mk(1, 0, 0, 10'h000, 1, 10'h008, 32'h02, 10'h010, 2, 0);
    vecs[7]  = mk(1, 1, 1, 10'h100, 0, 10'h000, 32'h00, 10'h100, 2, 0);
    vecs[8]  = mk(1, 1, 0, 10'h000, 1, 10'h100, 32'h40, 10'h104, 2, 0);
    vecs[9]  = mk(1, 1, 0, 10'h000, 1, 10'h104, 32'h41, 10'h108, 3, 0);
    vecs[10] = mk(1, 1, 1, 10'h3F8, 0, 10'h000, 32'h00, 10'h3F8, 3, 0);
    vecs[11] = mk(1, 1, 0, 10'h000, 1, 10'h3F8, 32'hFE, 10'h3FC, 3, 0);
    vecs[12] = mk(1, 1, 0, 10'h000, 1, 10'h3FC, 32'hFF, 10'h000, 4, 0);
    vecs[13] = mk(1, 1, 0, 10'h000, 1, 10'h000, 32'h00, 10'h004, 5, 0);
    vecs[14] = mk(0, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h008, 5, 0);
    vecs[15] = mk(0, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h008, 5, 0);
    vecs[16] = mk(0, 1, 1, 10'h200, 0, 10'h000, 32'h00, 10'h200, 5, 0);
    vecs[17] = mk(1, 1, 0, 10'h000, 0, 10'h000, 32'h00, 10'h200, 5, 0);
    vecs[18] = mk(1, 1, 0, 10'h000, 1, 10'h200, 32'h80, 10'h204, 5, 0);
    vecs[19] = mk(1, 1, 0, 10'h000, 1, 10'h204, 32'h81, 10'h208, 6, 0);
    // Segment 2: after a mid-stream reset, six cycles of back-pressure,
    // then drain.
    vecs[20] = mk(1, 0, 0, 10'h000, 0, 10'h000, 32'h00, 10'h000, 0, 0);
    vecs[21] = mk(1, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h004, 0, 0);
    vecs[22] = mk(1, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h008, 0, 0);
    vecs[23] = mk(1, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h008, 0, 0);
    vecs[24] = mk(1, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h008, 0, 0);
    vecs[25] = mk(1, 0, 0, 10'h000, 1, 10'h000, 32'h00, 10'h008, 0, 0);
    vecs[26] = mk(1, 1, 0, 10'h000, 1, 10'h004, 32'h01, 10'h00C, 1, 0);
    vecs[27] = mk(1, 1, 0, 10'h000, 1, 10'h008, 32'h02, 10'h010, 2, 0);
    // Segment 3: misaligned redirect to 0x102.
`ifdef IFU_MISALIGN_CHECK_EN
    vecs[28] = mk(1, 1, 1, 10'h102, 0, 10'h000, 32'h00, 10'h102, 2, 1);
    vecs[29] = mk(1, 1, 0, 10'h000, 0, 10'h000, 32'h00, 10'h102, 2, 1);
    vecs[30] = mk(1, 1, 0, 10'h000, 0, 10'h000, 32'h00, 10'h102, 2, 1);
`else
    vecs[28] = mk(1, 1, 1, 10'h102, 0, 10'h000, 32'h00, 10'h100, 2, 0);
    vecs[29] = mk(1, 1, 0, 10'h000, 1, 10'h100, 32'h40, 10'h104, 2, 0);
    vecs[30] = mk(1, 1, 0, 10'h000, 1, 10'h104, 32'h41, 10'h108, 3, 0);
`endif

    // Power-on reset.
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 10'h000;
    #12;
    checkResetState(100);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(i);
    end

    // Mid-stream asynchronous reset must clear outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState(101);
    @(posedge clk);
    #1;
    checkResetState(102);
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    rst_n     = 1'b1;

    for (int i = 20; i < NUM_VECS; i++) begin
      applyStimulus(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
